// File: rtl/lfosc_trim_cal.sv
// lfosc_trim_cal: calibration sequencer for the low-speed (10 kHz) oscillator.
// It powers the oscillator up and measures CLKLF against clk. A 10-step
// successive-approximation search on TRIM brings the LF period to
// TARGET_COUNT, and one extra verify window decides locked.
module lfosc_trim_cal #(
    parameter int         REF_CYCLES   = 16,
    parameter int         TARGET_COUNT = 19200,
    parameter int         TOL          = 16,
    parameter int         PU_WAIT      = 1200,
    parameter int         TIMEOUT      = 4096,
    parameter int         CNT_W        = 20,
    parameter logic [9:0] TRIM_INIT    = 10'h200
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             lf_clk,
    output logic             lf_pu,
    output logic             lf_en,
    output logic [9:0]       trim,
    output logic             busy,
    output logic             done,
    output logic             locked,
    output logic             error,
    output logic [CNT_W-1:0] meas_count
);

    localparam int PU_W  = $clog2(PU_WAIT + 1);
    localparam int GAP_W = $clog2(TIMEOUT + 1);

    localparam logic [PU_W-1:0]  PU_LAST  = PU_W'(PU_WAIT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT - 1);
    localparam logic [7:0]       WIN_LAST = 8'(REF_CYCLES - 1);
    localparam logic [CNT_W:0]   TARGET_X = (CNT_W + 1)'(TARGET_COUNT);
    localparam logic [CNT_W:0]   TOL_X    = (CNT_W + 1)'(TOL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POWERUP,
        S_SETTLE,
        S_MEASURE,
        S_ADJUST,
        S_FINISH
    } state_t;

    state_t           state;
    logic             lf_s1, lf_s2, lf_s3, lf_rise;
    logic [PU_W-1:0]  pu_cnt;
    logic [GAP_W-1:0] gap;
    logic [7:0]       win_cnt;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_idx;
    logic             settle_cnt;
    logic             verify;

    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W:0]   diff;
    logic             timeout_hit;

    // Bring lf_clk into the clk domain and turn its rising edge into a registered pulse.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            lf_s1   <= 1'b0;
            lf_s2   <= 1'b0;
            lf_s3   <= 1'b0;
            lf_rise <= 1'b0;
        end else begin
            lf_s1   <= lf_clk;
            lf_s2   <= lf_s1;
            lf_s3   <= lf_s2;
            lf_rise <= lf_s2 & ~lf_s3;
        end
    end

    // Saturating counter increment, lock distance and gap timeout detection.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        cnt_inc     = (&cnt) ? cnt : cnt + 1'b1;
        diff        = ({1'b0, meas_count} >= TARGET_X) ? ({1'b0, meas_count} - TARGET_X)
                                                       : (TARGET_X - {1'b0, meas_count});
        timeout_hit = ((state == S_SETTLE) || (state == S_MEASURE)) && !lf_rise && (gap == GAP_LAST);
    end

    // Calibration sequencer: power-up, settle, measure windows, SAR trim steps, finish.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            lf_pu      <= 1'b0;
            lf_en      <= 1'b0;
            trim       <= TRIM_INIT;
            busy       <= 1'b0;
            done       <= 1'b0;
            locked     <= 1'b0;
            error      <= 1'b0;
            meas_count <= '0;
            pu_cnt     <= '0;
            gap        <= '0;
            win_cnt    <= '0;
            cnt        <= '0;
            bit_idx    <= 4'd9;
            settle_cnt <= 1'b0;
            verify     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (timeout_hit) begin
                // The oscillator stopped toggling: shut it down and report.
                error  <= 1'b1;
                done   <= 1'b1;
                busy   <= 1'b0;
                lf_en  <= 1'b0;
                lf_pu  <= 1'b0;
                trim   <= TRIM_INIT;
                locked <= 1'b0;
                state  <= S_IDLE;
            end else begin
                if ((state == S_SETTLE) || (state == S_MEASURE)) begin
                    gap <= lf_rise ? '0 : gap + 1'b1;
                end
                case (state)
                    S_IDLE: begin
                        // A start coinciding with the done pulse belongs to the finished run.
                        if (start && !done) begin
                            lf_pu   <= 1'b1;
                            lf_en   <= 1'b0;
                            busy    <= 1'b1;
                            locked  <= 1'b0;
                            error   <= 1'b0;
                            trim    <= TRIM_INIT;
                            bit_idx <= 4'd9;
                            verify  <= 1'b0;
                            pu_cnt  <= '0;
                            state   <= S_POWERUP;
                        end
                    end
                    S_POWERUP: begin
                        if (pu_cnt == PU_LAST) begin
                            lf_en      <= 1'b1;
                            gap        <= '0;
                            settle_cnt <= 1'b0;
                            state      <= S_SETTLE;
                        end else begin
                            pu_cnt <= pu_cnt + 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        // Discard edges until the one that opens the next window.
                        if (lf_rise) begin
                            if (settle_cnt) begin
                                cnt     <= '0;
                                win_cnt <= '0;
                                state   <= S_MEASURE;
                            end else begin
                                settle_cnt <= 1'b1;
                            end
                        end
                    end
                    S_MEASURE: begin
                        cnt <= cnt_inc;
                        if (lf_rise) begin
                            if (win_cnt == WIN_LAST) begin
                                meas_count <= cnt_inc;
                                state      <= verify ? S_FINISH : S_ADJUST;
                            end else begin
                                win_cnt <= win_cnt + 1'b1;
                            end
                        end
                    end
                    S_ADJUST: begin
                        // Count at or below target means the oscillator is fast enough: drop the bit.
                        if (meas_count <= TARGET_X[CNT_W-1:0]) begin
                            trim[bit_idx] <= 1'b0;
                        end
                        if (bit_idx != 4'd0) begin
                            trim[bit_idx - 4'd1] <= 1'b1;
                            bit_idx              <= bit_idx - 4'd1;
                        end else begin
                            verify <= 1'b1;
                        end
                        // One edge re-opens the window; it is not counted.
                        settle_cnt <= 1'b1;
                        gap        <= '0;
                        state      <= S_SETTLE;
                    end
                    S_FINISH: begin
                        locked <= (diff <= TOL_X);
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfosc_trim_cal.sv
// tb_lfosc_trim_cal: behavioural LF oscillator plus scoreboard of expected
// window counts, driven by a directed sequence of calibration runs.
module tb_lfosc_trim_cal;

    localparam int         REF_CYCLES   = 4;
    localparam int         TARGET_COUNT = 480;
    localparam int         TOL          = 4;
    localparam int         PU_WAIT      = 100;
    localparam int         TIMEOUT      = 512;
    localparam int         CNT_W        = 20;
    localparam logic [9:0] TRIM_INIT    = 10'h200;
    localparam int         DONE_BUDGET  = 20000;

    logic             clk    = 1'b0;
    logic             resetn = 1'b0;
    logic             start  = 1'b0;
    logic             lf_clk = 1'b0;
    logic             lf_pu, lf_en, busy, done, locked, error;
    logic [9:0]       trim;
    logic [CNT_W-1:0] meas_count;

    always #5 clk = ~clk;

    lfosc_trim_cal #(
        .REF_CYCLES(REF_CYCLES), .TARGET_COUNT(TARGET_COUNT), .TOL(TOL),
        .PU_WAIT(PU_WAIT), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .TRIM_INIT(TRIM_INIT)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .lf_clk(lf_clk),
        .lf_pu(lf_pu), .lf_en(lf_en), .trim(trim), .busy(busy), .done(done),
        .locked(locked), .error(error), .meas_count(meas_count)
    );

    int compared   = 0;
    int mismatched = 0;

    // Oscillator model controls and scoreboard.
    int   osc_off   = 0;
    bit   osc_floor = 1'b0;
    bit   osc_stuck = 1'b0;
    int   exp_q[$];
    logic [9:0] exp_trim;
    int   exp_meas   = 0;
    logic exp_locked;
    int   done_cnt   = 0;

    int   phase = 0, per = 1, pc = 0, rc = 0, cmp_dly = 0;
    logic lf_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // LF period in clk cycles: larger trim -> faster oscillator -> shorter period.
    function automatic int base_period(input logic [9:0] t);
        int pb;
        pb = 120 + osc_off + (512 - int'(t)) / 16;
        if (osc_floor && pb < 125) pb = 125;
        return pb;
    endfunction

    // Any REF_CYCLES=4 consecutive periods contain exactly one stretched period in floor mode.
    function automatic int model_count(input logic [9:0] t);
        return REF_CYCLES * base_period(t) + (osc_floor ? 2 : 0);
    endfunction

    // SAR reference: queue the 10 search counts and the verify count.
    task automatic predict();
        logic [9:0] t;
        int c;
        t = TRIM_INIT;
        for (int b = 9; b >= 0; b--) begin
            t[b] = 1'b1;
            c = model_count(t);
            exp_q.push_back(c);
            if (c <= TARGET_COUNT) t[b] = 1'b0;
        end
        c = model_count(t);
        exp_q.push_back(c);
        exp_trim   = t;
        exp_meas   = c;
        exp_locked = ((c >= TARGET_COUNT) ? c - TARGET_COUNT : TARGET_COUNT - c) <= TOL;
    endtask

    // Oscillator model and window monitor; a window closes on rise 2+REF, then every REF+1 rises.
    always @(negedge clk) begin
        if (cmp_dly > 0) begin
            cmp_dly--;
            if (cmp_dly == 0) begin
                if (exp_q.size() == 0) check("extra_window", 32'd1, 32'd0);
                else check("window_count", 32'(meas_count), 32'(exp_q.pop_front()));
            end
        end
        if (lf_en !== 1'b1) begin
            lf_clk  = 1'b0;
            phase   = 0;
            pc      = 0;
            rc      = 0;
            cmp_dly = 0;
        end else begin
            if (osc_stuck) begin
                lf_clk = 1'b0;
            end else begin
                if (phase == 0) begin
                    per = base_period(trim) + ((osc_floor && (pc % 4 == 0)) ? 2 : 0);
                    pc++;
                end
                lf_clk = (phase < per / 2);
                phase++;
                if (phase >= per) phase = 0;
            end
            if (lf_clk && !lf_prev && busy === 1'b1) begin
                rc++;
                if (rc >= 2 + REF_CYCLES && (rc - 2 - REF_CYCLES) % (REF_CYCLES + 1) == 0) cmp_dly = 5;
            end
        end
        lf_prev = lf_clk;
        if (done === 1'b1) done_cnt++;
    end

    task automatic start_cal(input bit push);
        int n;
        if (push) predict();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("lf_pu_after_start", 32'(lf_pu), 32'd1);
        check("lf_en_low_after_start", 32'(lf_en), 32'd0);
        n = 1;
        while (lf_en !== 1'b1 && n < PU_WAIT + 20) begin
            @(negedge clk);
            n++;
        end
        check("lf_en_delay", 32'(n), 32'(PU_WAIT + 1));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < DONE_BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= DONE_BUDGET) check("done_wait", 32'd0, 32'd1);
    endtask

    task automatic full_cal(input string tag);
        int d0;
        d0 = done_cnt;
        start_cal(1'b1);
        wait_done();
        check({tag, "_trim"}, 32'(trim), 32'(exp_trim));
        check({tag, "_meas"}, 32'(meas_count), 32'(exp_meas));
        check({tag, "_locked"}, 32'(locked), 32'(exp_locked));
        check({tag, "_error"}, 32'(error), 32'd0);
        @(negedge clk);
        check({tag, "_done_width"}, 32'(done), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_windows_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        int d0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_lf_pu", 32'(lf_pu), 32'd0);
        check("rst_lf_en", 32'(lf_en), 32'd0);
        check("rst_trim", 32'(trim), 32'(TRIM_INIT));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_meas", 32'(meas_count), 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal oscillator; final count lands exactly TOL away from target.
        osc_off = 0; osc_floor = 1'b0; osc_stuck = 1'b0;
        full_cal("nominal");

        // Slow oscillator: search must raise trim above TRIM_INIT.
        osc_off = 4;
        full_cal("slow");

        // Oscillator that cannot get closer than 502 counts: completes unlocked.
        osc_off = 0; osc_floor = 1'b1;
        full_cal("floor");

        // Dead oscillator: timeout TIMEOUT cycles after lf_en, oscillator shut down.
        osc_floor = 1'b0; osc_stuck = 1'b1;
        d0 = done_cnt;
        start_cal(1'b0);
        n = 0;
        while (done !== 1'b1 && n < TIMEOUT + 50) begin
            @(negedge clk);
            n++;
        end
        check("timeout_delay", 32'(n), 32'(TIMEOUT));
        check("timeout_error", 32'(error), 32'd1);
        check("timeout_lf_pu", 32'(lf_pu), 32'd0);
        check("timeout_lf_en", 32'(lf_en), 32'd0);
        check("timeout_trim", 32'(trim), 32'(TRIM_INIT));
        check("timeout_locked", 32'(locked), 32'd0);
        check("timeout_meas_held", 32'(meas_count), 32'(exp_meas));
        repeat (3) @(negedge clk);
        check("timeout_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("timeout_busy", 32'(busy), 32'd0);

        // Reset in the middle of the third measurement window.
        osc_stuck = 1'b0;
        d0 = done_cnt;
        start_cal(1'b1);
        n = 0;
        while (exp_q.size() > 9 && n < DONE_BUDGET) begin
            @(negedge clk);
            n++;
        end
        repeat (200) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("abort_lf_pu", 32'(lf_pu), 32'd0);
        check("abort_lf_en", 32'(lf_en), 32'd0);
        check("abort_trim", 32'(trim), 32'(TRIM_INIT));
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_locked", 32'(locked), 32'd0);
        check("abort_error", 32'(error), 32'd0);
        check("abort_meas", 32'(meas_count), 32'd0);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        exp_q.delete();
        full_cal("after_abort");

        // Start pulses while busy and during the done cycle are ignored.
        d0 = done_cnt;
        start_cal(1'b1);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (300) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("ignored_busy", 32'(busy), 32'd1);
        wait_done();
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("done_start_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("done_start_busy2", 32'(busy), 32'd0);
        check("done_start_lf_en", 32'(lf_en), 32'd1);
        check("ignored_trim", 32'(trim), 32'(exp_trim));
        repeat (3) @(negedge clk);
        check("ignored_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("ignored_windows_left", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
